safety_obi_mem_responder: RTL and testbench
===========================================

// Module: safety_obi_mem_responder
// PURPOSE
//  OBI responder (req/gnt/rvalid/err) terminating a core instruction/data port on a fixed-latency SRAM macro.
//  Sits between the safety-island cv32e40p memory interface (or its interconnect) and one SRAM bank.
//  Grants requests subject to SRAM arbitration and an outstanding-transaction limit.
//  Returns responses strictly in order; out-of-range addresses get an error response without an SRAM access.
// PARAMETERS
//  AddrWidth       32            byte address width of the OBI port
//  DataWidth       32            data width; BE width = DataWidth/8
//  MemBaseAddr     32'h0000_0000 byte base address of the bank
//  MemSizeBytes    65536         bank size, power of two, >= DataWidth/8
//  SramLatency     1             SRAM read latency in cycles, 1..4
//  MaxOutstanding  2             max accepted-but-unanswered transactions, 1..8
// PORTS
//  clk_i         in   1          clock
//  rst_i         in   1          asynchronous reset, active high
//  req_i         in   1          OBI request valid
//  gnt_o         out  1          OBI grant; transfer accepted when req_i & gnt_o
//  addr_i        in   AddrWidth  byte address
//  we_i          in   1          1 = write
//  be_i          in   DW/8       byte enables
//  wdata_i       in   DW         write data
//  rvalid_o      out  1          response valid (core always accepts)
//  rdata_o       out  DW         read data
//  err_o         out  1          error response, valid with rvalid_o
//  sram_req_o    out  1          SRAM access request
//  sram_gnt_i    in   1          SRAM arbiter grant, same cycle
//  sram_we_o     out  1          SRAM write enable
//  sram_addr_o   out  $clog2(MemSizeBytes/(DW/8))  word address
//  sram_be_o     out  DW/8       SRAM byte enables
//  sram_wdata_o  out  DW         SRAM write data
//  sram_rdata_i  in   DW         SRAM read data, valid SramLatency cycles after granted read
// BEHAVIOUR
//  - Reset: gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, sram_req_o=0; outstanding count=0; tag pipe cleared.
//  - in_range = (addr_i - MemBaseAddr) < MemSizeBytes, unsigned, AddrWidth bits (wrap below base => out of range).
//  - slot_free = (cnt < MaxOutstanding) | rvalid_o  (slot released by this cycle's response is reusable).
//  - sram_req_o = req_i & in_range & slot_free; SRAM fields combinational from OBI inputs; addr = offset >> log2(DW/8).
//  - gnt_o = req_i & slot_free & (in_range ? sram_gnt_i : 1). gnt_o is never asserted without req_i.
//  - On accept push tag {valid=1, err=~in_range, we} into a SramLatency-deep shift pipe; no accept => valid=0 bubble.
//  - Pipe output after exactly SramLatency cycles: rvalid_o=1; err_o=tag.err;
//    rdata_o = err ? ErrRdata(32'hBADCAB1E) : we ? 0 : sram_rdata_i. Outputs zero when rvalid_o=0.
//  - Latency: accept in cycle t -> rvalid_o in cycle t+SramLatency, errors included (preserves order, no reorder buffer).
//  - cnt: +1 on accept, -1 on rvalid_o, unchanged on both; never exceeds MaxOutstanding (assertion).
//  - Back-to-back: with MaxOutstanding >= SramLatency one transfer per cycle sustained; else throughput MaxOutstanding/SramLatency.
//  - sram_gnt_i=0 with in-range req: gnt_o=0, request held by core, no tag pushed; out-of-range still granted.
//  - Writes: SRAM write happens in accept cycle; response rdata=0, err=0.
//  - Reset mid-operation: in-flight responses discarded, no rvalid_o emitted for them.
// STRUCTURE
//  - safety_island_pkg: obi_rsp_tag_t {valid, err, we}; ErrRdata constant (shared with reg_err_slv usage).
//  - Sub-module safety_obi_rsp_pipe: parameterised SramLatency-stage shift register of obi_rsp_tag_t with async active-high reset.
//  - Top: range check, grant logic, outstanding counter, response mux.
// TESTING
//  - Single read, SramLatency=1, addr=Base+0x10, SRAM word4=0xCAFE_F00D -> gnt same cycle, rvalid next cycle, rdata=0xCAFE_F00D, err=0.
//  - Write be=4'b0011 wdata=0x1234_5678 to Base+0x8 -> sram_we=1, sram_addr=2, sram_be=0011; rvalid t+1, rdata=0, err=0.
//  - Read addr=Base+MemSizeBytes -> sram_req_o=0, gnt=1, rvalid after SramLatency with err=1, rdata=0xBADCAB1E.
//  - SramLatency=3, MaxOutstanding=2, continuous reads -> gnt pattern 1,1,0,1,1,0...; cnt max 2; responses in address order.
//  - sram_gnt_i low 5 cycles with req held -> gnt_o=0 for 5 cycles, no rvalid, cnt=0; grant on 6th cycle.
//  - Assert rst_i with 2 reads in flight -> all outputs 0 next edge, no stale rvalid_o after release, cnt=0.

Source files
------------

// File: rtl/safety_obi_mem_responder_pkg.sv
// Shared types for the OBI SRAM responder: in-flight response tag and
// the read data returned with an error response.
package safety_obi_mem_responder_pkg;

    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } obi_rsp_tag_t;

    localparam logic [31:0] ErrRdata = 32'hBADC_AB1E;

endpackage

// File: rtl/safety_obi_mem_responder_rsp_pipe.sv
// Fixed-depth shift register carrying response tags alongside the SRAM
// read latency, so every response leaves exactly Depth cycles after accept.
module safety_obi_mem_responder_rsp_pipe
    import safety_obi_mem_responder_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  obi_rsp_tag_t tag_i,
    output obi_rsp_tag_t tag_o
);

    obi_rsp_tag_t stage_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/safety_obi_mem_responder.sv
// OBI responder for one fixed-latency SRAM bank: range check, grant and
// outstanding-limit logic, in-order response generation.
module safety_obi_mem_responder
    import safety_obi_mem_responder_pkg::*;
#(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter logic [AddrWidth-1:0] MemBaseAddr    = '0,
    parameter int unsigned          MemSizeBytes   = 65536,
    parameter int unsigned          SramLatency    = 1,
    parameter int unsigned          MaxOutstanding = 2,
    localparam int unsigned         BeWidth        = DataWidth / 8,
    localparam int unsigned         SramAw         = $clog2(MemSizeBytes / BeWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    output logic                 sram_req_o,
    input  logic                 sram_gnt_i,
    output logic                 sram_we_o,
    output logic [SramAw-1:0]    sram_addr_o,
    output logic [BeWidth-1:0]   sram_be_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam int unsigned ByteOffW = $clog2(BeWidth);
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);

    logic [AddrWidth-1:0] offset;
    logic                 in_range;
    logic                 slot_free;
    logic                 accept;
    logic [CntW-1:0]      cnt_q, cnt_d;
    obi_rsp_tag_t         tag_push, tag_pop;

    // Unsigned subtraction makes addresses below the base wrap to huge offsets.
    assign offset    = addr_i - MemBaseAddr;
    assign in_range  = offset < AddrWidth'(MemSizeBytes);
    assign slot_free = (cnt_q < CntW'(MaxOutstanding)) | tag_pop.valid;

    assign gnt_o  = req_i & slot_free & (~in_range | sram_gnt_i);
    assign accept = gnt_o;

    assign sram_req_o   = req_i & in_range & slot_free;
    assign sram_we_o    = we_i;
    assign sram_addr_o  = SramAw'(offset >> ByteOffW);
    assign sram_be_o    = be_i;
    assign sram_wdata_o = wdata_i;

    assign tag_push.valid = accept;
    assign tag_push.err   = accept & ~in_range;
    assign tag_push.we    = accept & we_i;

    safety_obi_mem_responder_rsp_pipe #(
        .Depth (SramLatency)
    ) u_rsp_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tag_i (tag_push),
        .tag_o (tag_pop)
    );

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, tag_pop.valid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Error responses never touched the SRAM, so its read port is ignored for them.
    always_comb begin
        rvalid_o = tag_pop.valid;
        err_o    = 1'b0;
        rdata_o  = '0;
        if (tag_pop.valid) begin
            err_o = tag_pop.err;
            if (tag_pop.err) begin
                rdata_o = DataWidth'(ErrRdata);
            end else if (!tag_pop.we) begin
                rdata_o = sram_rdata_i;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CntW'(MaxOutstanding));
    assert property (@(posedge clk_i) disable iff (rst_i) gnt_o |-> req_i);

endmodule

// File: tb/tb_safety_obi_mem_responder.sv
// Scoreboard bench: lane A (latency 1, base 0) and lane B (latency 3,
// base 0x2000_0000) each drive one responder against a simple SRAM model.
module tb_safety_obi_mem_responder;

    localparam logic [31:0] BaseA  = 32'h0000_0000;
    localparam logic [31:0] SizeA  = 32'd65536;
    localparam int          LatA   = 1;
    localparam logic [31:0] BaseB  = 32'h2000_0000;
    localparam logic [31:0] SizeB  = 32'd4096;
    localparam int          LatB   = 3;
    localparam int          MaxOut = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    logic        req_a, we_a, gnt_a, rvalid_a, err_a, sram_req_a, sram_gnt_a, sram_we_a;
    logic [31:0] addr_a, wdata_a, rdata_a, sram_wdata_a, sram_rdata_a;
    logic [3:0]  be_a, sram_be_a;
    logic [13:0] sram_addr_a;

    logic        req_b, we_b, gnt_b, rvalid_b, err_b, sram_req_b, sram_gnt_b, sram_we_b;
    logic [31:0] addr_b, wdata_b, rdata_b, sram_wdata_b, sram_rdata_b;
    logic [3:0]  be_b, sram_be_b;
    logic [9:0]  sram_addr_b;

    safety_obi_mem_responder #(
        .MemBaseAddr (BaseA), .MemSizeBytes (65536), .SramLatency (LatA), .MaxOutstanding (MaxOut)
    ) u_dut_a (
        .clk_i (clk_sys), .rst_i (rst), .req_i (req_a), .gnt_o (gnt_a), .addr_i (addr_a),
        .we_i (we_a), .be_i (be_a), .wdata_i (wdata_a), .rvalid_o (rvalid_a), .rdata_o (rdata_a),
        .err_o (err_a), .sram_req_o (sram_req_a), .sram_gnt_i (sram_gnt_a), .sram_we_o (sram_we_a),
        .sram_addr_o (sram_addr_a), .sram_be_o (sram_be_a), .sram_wdata_o (sram_wdata_a),
        .sram_rdata_i (sram_rdata_a)
    );

    safety_obi_mem_responder #(
        .MemBaseAddr (BaseB), .MemSizeBytes (4096), .SramLatency (LatB), .MaxOutstanding (MaxOut)
    ) u_dut_b (
        .clk_i (clk_sys), .rst_i (rst), .req_i (req_b), .gnt_o (gnt_b), .addr_i (addr_b),
        .we_i (we_b), .be_i (be_b), .wdata_i (wdata_b), .rvalid_o (rvalid_b), .rdata_o (rdata_b),
        .err_o (err_b), .sram_req_o (sram_req_b), .sram_gnt_i (sram_gnt_b), .sram_we_o (sram_we_b),
        .sram_addr_o (sram_addr_b), .sram_be_o (sram_be_b), .sram_wdata_o (sram_wdata_b),
        .sram_rdata_i (sram_rdata_b)
    );

    // ---------------- SRAM models ----------------
    function automatic logic [31:0] init_a(input int w);
        return (w == 4) ? 32'hCAFE_F00D : (32'hA5A5_0000 | 32'(w));
    endfunction

    function automatic logic [31:0] init_b(input int w);
        return 32'h5B00_0000 | 32'(w);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    logic        mem_clr;
    logic [31:0] wr_a  [64];
    logic        wvld_a[64];
    logic [31:0] rd_b  [3];

    function automatic logic [31:0] mem_a_rd(input int w);
        return (w < 64 && wvld_a[w]) ? wr_a[w] : init_a(w);
    endfunction

    always @(posedge clk_sys) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) wvld_a[i] <= 1'b0;
            sram_rdata_a <= 32'hDEAD_BEEF;
        end else if (sram_req_a && sram_gnt_a) begin
            if (sram_we_a) begin
                if (int'(sram_addr_a) < 64) begin
                    wr_a[sram_addr_a[5:0]]   <= merge(mem_a_rd(int'(sram_addr_a)), sram_wdata_a, sram_be_a);
                    wvld_a[sram_addr_a[5:0]] <= 1'b1;
                end
                sram_rdata_a <= 32'hDEAD_BEEF;
            end else begin
                sram_rdata_a <= mem_a_rd(int'(sram_addr_a));
            end
        end else begin
            sram_rdata_a <= 32'hDEAD_BEEF;
        end
    end

    always @(posedge clk_sys) begin
        rd_b[0] <= (sram_req_b && sram_gnt_b && !sram_we_b) ? init_b(int'(sram_addr_b)) : 32'hDEAD_BEEF;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign sram_rdata_b = rd_b[2];

    // ---------------- reference memory & scoreboard ----------------
    logic [31:0] ref_wr [64];
    logic        ref_vld[64];
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        e_a, e_b;

    logic        last_sram_req, last_sram_we;
    logic [31:0] last_sram_addr, last_sram_wdata;
    logic [3:0]  last_sram_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int lane, input logic req, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
        if (lane == 0) begin
            req_a = req; addr_a = addr; we_a = we; be_a = be; wdata_a = wdata;
        end else begin
            req_b = req; addr_b = addr; we_b = we; be_b = be; wdata_b = wdata;
        end
    endtask

    task automatic idle(input int lane);
        drive(lane, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    // Holds req until granted; returns at posedge+1 after the accept cycle.
    task automatic xfer(input int lane, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata, output int waits);
        exp_t        e;
        logic        got;
        logic [31:0] off, size;
        int          w;
        drive(lane, 1'b1, addr, we, be, wdata);
        waits = 0;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_sys);
            if (lane == 0 ? gnt_a : gnt_b) begin
                got             = 1'b1;
                last_sram_req   = lane == 0 ? sram_req_a : sram_req_b;
                last_sram_we    = lane == 0 ? sram_we_a : sram_we_b;
                last_sram_addr  = lane == 0 ? 32'(sram_addr_a) : 32'(sram_addr_b);
                last_sram_be    = lane == 0 ? sram_be_a : sram_be_b;
                last_sram_wdata = lane == 0 ? sram_wdata_a : sram_wdata_b;
                off   = addr - (lane == 0 ? BaseA : BaseB);
                size  = lane == 0 ? SizeA : SizeB;
                w     = int'(off >> 2);
                e.cyc = cyc + (lane == 0 ? LatA : LatB);
                if (off >= size) begin
                    e.err = 1'b1; e.rdata = 32'hBADC_AB1E;
                end else if (we) begin
                    e.err = 1'b0; e.rdata = 32'h0;
                    if (lane == 0 && w < 64) begin
                        ref_wr[w]  = merge(ref_vld[w] ? ref_wr[w] : init_a(w), wdata, be);
                        ref_vld[w] = 1'b1;
                    end
                end else begin
                    e.err   = 1'b0;
                    e.rdata = (lane == 0) ? ((w < 64 && ref_vld[w]) ? ref_wr[w] : init_a(w)) : init_b(w);
                end
                if (lane == 0) q_a.push_back(e); else q_b.push_back(e);
            end else begin
                waits++;
            end
            @(posedge clk_sys); #1;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL xfer_timeout: lane %0d addr %h never granted", lane, addr);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk_sys) begin
        if (!rst) begin
            if (rvalid_a) begin
                if (q_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_a_unexpected: rvalid with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    e_a = q_a.pop_front();
                    chk("rsp_a_rdata", rdata_a, e_a.rdata);
                    chk("rsp_a_err", 32'(err_a), 32'(e_a.err));
                    chk("rsp_a_cycle", cyc, e_a.cyc);
                end
            end else begin
                chk("idle_a_zero", rdata_a | 32'(err_a), 32'h0);
            end
        end
    end

    always @(negedge clk_sys) begin
        if (!rst) begin
            chk("cnt_b_le_max", 32'(u_dut_b.cnt_q <= 2'(MaxOut)), 32'h1);
            if (rvalid_b) begin
                if (q_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_b_unexpected: rvalid with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    e_b = q_b.pop_front();
                    chk("rsp_b_rdata", rdata_b, e_b.rdata);
                    chk("rsp_b_err", 32'(err_b), 32'(e_b.err));
                    chk("rsp_b_cycle", cyc, e_b.cyc);
                end
            end else begin
                chk("idle_b_zero", rdata_b | 32'(err_b), 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    int w;
    int exp_w[6] = '{0, 0, 1, 0, 1, 0};

    initial begin
        for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;
        rst = 1'b0; mem_clr = 1'b1;
        sram_gnt_a = 1'b1; sram_gnt_b = 1'b1;
        idle(0); idle(1);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("rst_gnt_a", 32'(gnt_a), 32'h0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'h0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'h0);
        chk("rst_out_a", rdata_a | 32'(err_a) | 32'(sram_req_a), 32'h0);
        chk("rst_cnt_b", 32'(u_dut_b.cnt_q), 32'h0);
        @(posedge clk_sys); #1;
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk_sys); #1;

        // single read of word 4
        xfer(0, BaseA + 32'h10, 1'b0, 4'hF, 32'h0, w);
        idle(0);
        chk("rd_gnt_wait", w, 0);
        chk("rd_sram_req", 32'(last_sram_req), 32'h1);
        chk("rd_sram_addr", last_sram_addr, 32'd4);

        // partial write then read-back
        xfer(0, BaseA + 32'h8, 1'b1, 4'b0011, 32'h1234_5678, w);
        idle(0);
        chk("wr_gnt_wait", w, 0);
        chk("wr_sram_we", 32'(last_sram_we), 32'h1);
        chk("wr_sram_addr", last_sram_addr, 32'd2);
        chk("wr_sram_be", 32'(last_sram_be), 32'b0011);
        chk("wr_sram_wdata", last_sram_wdata, 32'h1234_5678);
        @(posedge clk_sys); #1;
        xfer(0, BaseA + 32'h8, 1'b0, 4'hF, 32'h0, w);
        idle(0);

        // first address past the bank, then last word inside it
        xfer(0, BaseA + SizeA, 1'b0, 4'hF, 32'h0, w);
        chk("oor_gnt_wait", w, 0);
        chk("oor_sram_req", 32'(last_sram_req), 32'h0);
        xfer(0, BaseA + SizeA - 32'd4, 1'b0, 4'hF, 32'h0, w);
        idle(0);
        chk("last_sram_req", 32'(last_sram_req), 32'h1);
        chk("last_sram_addr", last_sram_addr, 32'd16383);
        repeat (2) @(posedge clk_sys); #1;

        // SRAM arbiter withholds grant for five cycles
        sram_gnt_a = 1'b0;
        drive(0, 1'b1, BaseA + 32'h20, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            chk("blk_gnt", 32'(gnt_a), 32'h0);
            chk("blk_cnt", 32'(u_dut_a.cnt_q), 32'h0);
            @(posedge clk_sys); #1;
        end
        sram_gnt_a = 1'b1;
        xfer(0, BaseA + 32'h20, 1'b0, 4'hF, 32'h0, w);
        idle(0);
        chk("blk_release_wait", w, 0);

        // lane B: streaming reads limited by two outstanding at latency 3
        for (int i = 0; i < 6; i++) begin
            xfer(1, BaseB + 32'(4 * i), 1'b0, 4'hF, 32'h0, w);
            chk("b2b_wait", w, exp_w[i]);
        end
        idle(1);

        // wrap below base, last in-range word, first word past the bank
        xfer(1, BaseB - 32'd4, 1'b0, 4'hF, 32'h0, w);
        chk("wrap_sram_req", 32'(last_sram_req), 32'h0);
        xfer(1, BaseB + SizeB - 32'd4, 1'b0, 4'hF, 32'h0, w);
        chk("b_last_sram_addr", last_sram_addr, 32'd1023);
        xfer(1, BaseB + SizeB, 1'b0, 4'hF, 32'h0, w);
        idle(1);
        for (int i = 0; i < 20 && q_b.size() > 0; i++) @(posedge clk_sys);
        #1;

        // reset with two reads in flight
        xfer(1, BaseB + 32'h40, 1'b0, 4'hF, 32'h0, w);
        xfer(1, BaseB + 32'h44, 1'b0, 4'hF, 32'h0, w);
        idle(1);
        rst = 1'b1;
        q_b.delete();
        @(negedge clk_sys);
        chk("mid_rst_rvalid_b", 32'(rvalid_b), 32'h0);
        chk("mid_rst_out_b", rdata_b | 32'(err_b) | 32'(gnt_b) | 32'(sram_req_b), 32'h0);
        chk("mid_rst_cnt_b", 32'(u_dut_b.cnt_q), 32'h0);
        @(posedge clk_sys); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk_sys); #1;
        chk("post_rst_cnt_b", 32'(u_dut_b.cnt_q), 32'h0);
        xfer(1, BaseB + 32'h8, 1'b0, 4'hF, 32'h0, w);
        idle(1);
        chk("post_rst_wait", w, 0);

        for (int i = 0; i < 50 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
